// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage
// Operands are latched as magnitudes; the sign fixup is applied on the last iteration edge.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] a_orig_q, a_orig_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // One restoring step: dvd_q shifts dividend bits out of its MSB and quotient bits into its LSB.
  always_comb begin
    rem_shift = {prem_q, dvd_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, bmag_q};
    qbit      = ~diff[WIDTH];
    prem_next = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    dvd_next  = {dvd_q[WIDTH-2:0], qbit};
    q_fix     = sign_q_q ? (~dvd_next + 1'b1) : dvd_next;
    r_fix     = sign_r_q ? (~prem_next + 1'b1) : prem_next;
    a_mag     = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag     = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    prem_d      = prem_q;
    bmag_d      = bmag_q;
    a_orig_d    = a_orig_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    valid_d     = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          stall    = 1'b1;
          dvd_d    = a_mag;
          bmag_d   = b_mag;
          a_orig_d = a;
          sign_q_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          sign_r_d = signed_div & a[WIDTH-1];
          zero_d   = (b == '0);
          cnt_d    = '0;
          prem_d   = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          dvd_d  = dvd_next;
          prem_d = prem_next;
          cnt_d  = cnt_q + 1'b1;
          // Results are registered on the final iteration edge so DONE is the valid cycle.
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            if (zero_q) begin
              quotient_d  = '1;
              remainder_d = a_orig_q;
              dbz_d       = 1'b1;
            end else begin
              quotient_d  = q_fix;
              remainder_d = r_fix;
              dbz_d       = 1'b0;
            end
          end
        end
      end
      S_DONE: begin
        stall   = ~valid_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      prem_q      <= '0;
      bmag_q      <= '0;
      a_orig_q    <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      prem_q      <= prem_d;
      bmag_q      <= bmag_d;
      a_orig_q    <= a_orig_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign valid       = valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall;
  logic        valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .stall      (stall),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz);
    int n;
    int stall_cnt;
    int vcyc;
    start = 1'b1; a = ta; b = tb_v; signed_div = ts;
    #1;
    n = 1; stall_cnt = 0; vcyc = 0;
    while (n <= 60 && vcyc == 0) begin
      if (valid) vcyc = n;
      else if (stall) stall_cnt++;
      if (vcyc == 0) begin
        step();
        start = 1'b0;
        n++;
      end
    end
    chk({tag, "_valid_cycle"}, vcyc, 34);
    chk({tag, "_stall_cycles"}, stall_cnt, 33);
    chk({tag, "_stall_in_valid"}, {31'b0, stall}, 32'd0);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
    step();
    chk({tag, "_valid_pulse"}, {31'b0, valid}, 32'd0);
    chk({tag, "_hold_q"}, quotient, eq);
  endtask

  initial begin
    int vcount;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    step();

    run_div("udiv", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    run_div("sdiv_neg_a", 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    run_div("sdiv_neg_b", 32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0);
    run_div("sovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
    run_div("umax", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_div("dbz_u", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1);
    run_div("dbz_s", 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1);
    run_div("pre_annul", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0);

    // Annul in the 10th BUSY cycle.
    start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("annul_busy_stall", {31'b0, stall}, 32'd1);
    annul = 1'b1;
    step();
    annul = 1'b0;
    chk("annul_stall_drop", {31'b0, stall}, 32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) vcount++;
      step();
    end
    chk("annul_no_valid", vcount, 0);
    chk("annul_q_kept", quotient, 32'd8);
    chk("annul_r_kept", remainder, 32'd2);
    run_div("post_annul", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0);

    // Reset in the middle of BUSY.
    start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mrst_quotient", quotient, 32'd0);
    chk("mrst_remainder", remainder, 32'd0);
    chk("mrst_valid", {31'b0, valid}, 32'd0);
    chk("mrst_stall", {31'b0, stall}, 32'd0);

    // start with annul in IDLE must not begin a divide.
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd2;
    #1;
    chk("sa_stall_now", {31'b0, stall}, 32'd0);
    step();
    start = 1'b0; annul = 1'b0;
    #1;
    chk("sa_stall_next", {31'b0, stall}, 32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) vcount++;
      step();
    end
    chk("sa_no_valid", vcount, 0);
    chk("sa_q_kept", quotient, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
